// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester packet arbiter feeding a UART transmit FIFO
//
// Grants the UART transmit FIFO to one of two byte-stream requesters at a
// time and holds the grant for a whole packet (until a byte with last=1 is
// accepted). Ties out of IDLE are broken round-robin using last_served.
// A grant whose owner stops presenting bytes for TIMEOUT cycles is revoked.
// Back-pressure (tx_full) with valid held high never counts toward timeout.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   reqN_valid     requester N presents a byte (N = 0, 1)
//   reqN_data      requester N byte
//   reqN_last      requester N byte ends its packet
//   reqN_ready     requester N byte accepted when high together with valid
//   tx_full        UART transmit FIFO full
//   wr_uart        write strobe into the UART transmit FIFO
//   w_data         byte written into the UART transmit FIFO
//   grant          one-hot current owner, 2'b00 when nobody owns the FIFO
//   timeout_pulse  one-cycle pulse when a grant is revoked by timeout

module uart_tx_arbiter #(
    parameter int TIMEOUT     = 1024,
    parameter int TIMEOUT_BIT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic [1:0] grant,
    output logic       timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [TIMEOUT_BIT-1:0] CNT_LIMIT = TIMEOUT_BIT'(TIMEOUT - 1);
    localparam logic [TIMEOUT_BIT-1:0] CNT_MAX   = '1;

    state_t                 state;
    logic                   last_served;
    logic [TIMEOUT_BIT-1:0] idle_cnt;

    logic xfer0;
    logic xfer1;
    logic own_valid;
    logic own_last;
    logic own_xfer;

    // Grant is decoded straight from the state register, so it drops to
    // 2'b00 the moment reset is asserted without waiting for a clock.
    assign grant[0] = (state == GNT0);
    assign grant[1] = (state == GNT1);

    assign req0_ready = grant[0] & ~tx_full;
    assign req1_ready = grant[1] & ~tx_full;

    assign xfer0 = req0_valid & req0_ready;
    assign xfer1 = req1_valid & req1_ready;

    // Zero-latency pass-through: the byte goes to the FIFO in the same cycle
    // it is accepted, so nothing is ever buffered here.
    assign wr_uart = xfer0 | xfer1;

    always_comb begin
        w_data = 8'h00;
        if (grant[0]) begin
            w_data = req0_data;
        end else if (grant[1]) begin
            w_data = req1_data;
        end
    end

    // Signals of whichever requester currently owns the grant.
    assign own_valid = grant[1] ? req1_valid : req0_valid;
    assign own_last  = grant[1] ? req1_last  : req0_last;
    assign own_xfer  = wr_uart;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            last_served   <= 1'b1;
            idle_cnt      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (req0_valid && req1_valid) begin
                        state <= last_served ? GNT0 : GNT1;
                    end else if (req0_valid) begin
                        state <= GNT0;
                    end else if (req1_valid) begin
                        state <= GNT1;
                    end
                end
                GNT0, GNT1: begin
                    if (own_xfer) begin
                        idle_cnt <= '0;
                        if (own_last) begin
                            state       <= IDLE;
                            last_served <= (state == GNT1);
                        end
                    end else if (!own_valid) begin
                        if (idle_cnt == CNT_LIMIT) begin
                            state         <= IDLE;
                            last_served   <= (state == GNT1);
                            timeout_pulse <= 1'b1;
                            idle_cnt      <= '0;
                        end else if (idle_cnt != CNT_MAX) begin
                            idle_cnt <= idle_cnt + TIMEOUT_BIT'(1);
                        end
                    end
                    // valid held high while tx_full: counter holds.
                end
                default: begin
                    state    <= IDLE;
                    idle_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1024: idle-cycle limit before a held grant is revoked.
REQ-002 Parameter TIMEOUT_BIT, default 10: width of the timeout counter; SHALL satisfy 2^TIMEOUT_BIT >= TIMEOUT.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has a byte.
REQ-006 req0_data  input  8  requester 0 byte.
REQ-007 req0_last  input  1  byte is the final byte of requester 0's packet.
REQ-008 req0_ready  output  1  requester 0 byte accepted this cycle when high with req0_valid.
REQ-009 req1_valid, req1_data[7:0], req1_last, req1_ready  same directions, widths and meanings as requester 0.
REQ-010 tx_full  input  1  UART transmit FIFO full.
REQ-011 wr_uart  output  1  write strobe to the UART transmit FIFO.
REQ-012 w_data  output  8  byte to the UART transmit FIFO.
REQ-013 grant  output  2  one-hot current owner (bit n = requester n); 2'b00 when no owner.
REQ-014 timeout_pulse  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 FSM states SHALL be IDLE, GNT0 and GNT1.
REQ-016 grant SHALL be 2'b01 in GNT0, 2'b10 in GNT1, and 2'b00 in IDLE.
REQ-017 reqN_ready SHALL be combinational: grant[N] && !tx_full.
REQ-018 A transfer on requester N occurs when reqN_valid && reqN_ready.
REQ-019 wr_uart SHALL equal the transfer condition of the granted requester and be 0 in IDLE (zero-cycle latency; wr_uart is never asserted while tx_full=1).
REQ-020 w_data SHALL be reqN_data of the granted requester and 8'h00 in IDLE.
REQ-021 A 1-bit priority pointer last_served SHALL record the most recently released owner.
REQ-022 IDLE, exactly one valid: go to that requester's GNT state next cycle.
REQ-023 IDLE, both valid: grant the requester not equal to last_served.
REQ-024 IDLE, neither valid: stay in IDLE.
REQ-025 No transfer SHALL occur in the IDLE cycle; the first byte of a packet is accepted at the earliest one cycle after valid is seen in IDLE.
REQ-026 GNTn, transfer with reqN_last=1: go to IDLE and set last_served=n.
REQ-027 GNTn, transfer with reqN_last=0: stay in GNTn; the grant SHALL NOT change mid-packet, regardless of the other requester.
REQ-028 The timeout counter SHALL clear on entering GNTn and on every transfer.
REQ-029 In GNTn, the timeout counter SHALL increment on each cycle with reqN_valid=0.
REQ-030 The timeout counter SHALL hold on cycles with reqN_valid=1 and tx_full=1; back-pressure never times out.
REQ-031 When the counter equals TIMEOUT-1 and reqN_valid=0, the next state SHALL be IDLE, last_served=n, and timeout_pulse=1 for exactly that one registered cycle.
REQ-032 A transfer in the same cycle as the timeout condition cannot occur, because timeout requires valid=0; no tie-break is needed.
REQ-033 The timeout counter SHALL saturate, never wrap, and be held at 0 in IDLE.
REQ-034 Requesters SHALL hold data, last and valid stable until accepted; the arbiter does not buffer any bytes.

Reset
REQ-035 Asynchronous assertion of reset SHALL force state=IDLE, last_served=1 (requester 0 wins the first tie), counter=0 and timeout_pulse=0.
REQ-036 Consequently, during and after reset: grant=00, wr_uart=0, w_data=8'h00, req0_ready=req1_ready=0.
REQ-037 Reset mid-packet SHALL drop ownership with no partial write; the requester must resend the packet.

Verification
REQ-038 Out of reset, req0 and req1 both raise valid simultaneously, 3-byte packets, tx_full=0 -> GNT0 first, bytes 0..2 written on consecutive cycles, 1 IDLE cycle, then GNT1 bytes written.
REQ-039 req0 sends 2 packets back to back while req1 is continuously valid -> order is req0 pkt, req1 pkt, req0 pkt (round-robin).
REQ-040 tx_full=1 for 5 cycles mid-packet with req0_valid=1 -> wr_uart=0 and req0_ready=0 for those cycles, no timeout, byte written on the first cycle tx_full=0.
REQ-041 req1 granted, sends 1 non-last byte, then valid=0 for TIMEOUT cycles with TIMEOUT=8 -> timeout_pulse high for one cycle, grant=00, a pending req0 granted next.
REQ-042 Reset asserted while GNT1 is mid-packet -> grant=00 and wr_uart=0 immediately (asynchronously); after release, a req0/req1 tie goes to req0.
